// File: rtl/reg_dump_pkg.sv
`default_nettype none
//==============================================================================
// Module      : reg_dump_pkg
// Description : Shared types and defaults for the register-dump reader.
//               DWIDTH/AWIDTH defaults match the reg_file they read from.
// Revision    : 1.0 - initial release
//==============================================================================
package reg_dump_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : reg_dump_pkg
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : reg_dump_ctrl
// Description : Walks an address range of reg_file through one read port and
//               streams each word out over valid/ready. The range may wrap
//               through DEPTH-1 to 0.
//               Optional feature: REG_DUMP_CHECKSUM_EN appends one XOR word
//               of everything sent in the dump.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] addr_lo,
    input  logic [AWIDTH-1:0] addr_hi,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rd,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_lo;
    logic [AWIDTH:0]   r_count;
    logic [DWIDTH-1:0] r_data;

    logic [AWIDTH-1:0] w_span;
    logic [AWIDTH:0]   w_words;
    logic              w_accept;
    logic              w_capture;
    logic              w_hs;
    logic              w_last_reg;
    logic              w_final;

    // Word count is one more than the modular span, so it needs AWIDTH+1 bits
    assign w_span     = addr_hi - addr_lo;
    assign w_words    = {1'b0, w_span} + {{AWIDTH{1'b0}}, 1'b1};

    assign w_accept   = start && (r_state == ST_IDLE);
    assign w_capture  = ((r_state == ST_READ) && (RD_LATENCY == 0)) || (r_state == ST_WAIT);
    assign w_hs       = (r_state == ST_SEND) && out_ready;
    assign w_last_reg = (r_count == {{AWIDTH{1'b0}}, 1'b1});

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DWIDTH-1:0] r_acc;
    logic              r_csum_phase;
    // The checksum word is the final one; the last register word is not
    assign w_final    = r_csum_phase;
`else
    assign w_final    = w_last_reg;
`endif

    assign ra        = (r_state == ST_IDLE) ? r_lo : r_addr;
    assign out_data  = r_data;
    assign out_valid = (r_state == ST_SEND);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one word per READ[/WAIT]/SEND pass
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                w_next = (RD_LATENCY == 0) ? ST_SEND : ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (w_final) begin
                        w_next = ST_DONE;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_next = w_last_reg ? ST_SEND : ST_READ;
`else
                        w_next = ST_READ;
`endif
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Address, word counter and output word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_lo    <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr_lo;
                r_lo    <= addr_lo;
                r_count <= w_words;
            end
            if (w_capture) begin
                r_data <= rd;
            end
            if (w_hs) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count - 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                // Swap in the checksum right after the last register word
                if (w_last_reg && !r_csum_phase) begin
                    r_data <= r_acc ^ r_data;
                end
`endif
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // Running XOR of sent words; cleared on each accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_csum_phase <= 1'b0;
        end else if (w_accept) begin
            r_acc        <= '0;
            r_csum_phase <= 1'b0;
        end else if (w_hs) begin
            r_acc <= r_acc ^ r_data;
            if (w_last_reg) begin
                r_csum_phase <= 1'b1;
            end
        end
    end
`endif

endmodule : reg_dump_ctrl
`default_nettype wire
